// File: rtl/apb_strb_completer_if.sv
// APB4 completer-side bus bundle for apb_strb_completer.
interface apb_strb_completer_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [31:0]       PWDATA;
    logic [3:0]        PSTRB;
    logic [31:0]       PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_strb_completer.sv
// APB4 completer: byte-strobed 32-bit register bank with programmable wait states and PSLVERR.
// Build macro RO_ID_EN turns register 0 into a read-only ID register.
module apb_strb_completer #(
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    apb_strb_completer_if.slave     apb,
    output logic [32*NUM_REGS-1:0]  regs_flat
);
    localparam int unsigned IDX_W = $clog2(NUM_REGS);
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_STATES);
    localparam logic             NO_WAIT   = (WAIT_STATES == 0);
    localparam logic [31:0]      ID_VALUE  = 32'hA9B0_0001;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    typedef struct packed {
        logic             write;
        logic             err;
        logic [IDX_W-1:0] idx;
        logic [31:0]      wdata;
        logic [3:0]       strb;
    } xfer_t;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [1:0]       phase_c;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    xfer_t            xfer_q;
    xfer_t            xfer_d;
    xfer_t            bus_x_c;
    xfer_t            resp_x_c;
    logic             pready_q;
    logic             pready_d;
    logic             pslverr_q;
    logic             pslverr_d;
    logic [31:0]      prdata_q;
    logic [31:0]      prdata_d;
    logic [31:0]      rd_word_c;
    logic [31:0]      rdata_c;
    logic             done_c;
    logic             setup_c;
    logic             commit_c;
    logic [31:0]      regs [NUM_REGS];

    // Classify a transfer from its address phase attributes.
    function automatic xfer_t decode(input logic [ADDR_W-1:0] addr,
                                     input logic              write,
                                     input logic [31:0]       wdata,
                                     input logic [3:0]        strb);
        xfer_t x;
        x.write = write;
        x.wdata = wdata;
        x.strb  = strb;
        x.idx   = addr[IDX_W+1:2];
        x.err   = (addr[1:0] != 2'b00)
                || (32'(addr[ADDR_W-1:2]) >= NUM_REGS)
                || (!write && (strb != 4'b0000));
`ifdef RO_ID_EN
        if (write && (32'(addr[ADDR_W-1:2]) == 32'd0)) begin
            x.err = 1'b1;
        end
`endif
        return x;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  strb);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                r[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return r;
    endfunction

    // The cycle holding PREADY is the last ACCESS cycle; a new SETUP may overlap it.
    assign done_c   = (state_q == ST_ACCESS) && (cnt_q == '0);
    assign setup_c  = apb.PSEL && !apb.PENABLE && ((state_q == ST_IDLE) || done_c);
    assign phase_c  = setup_c ? ST_SETUP : state_q;
    assign commit_c = done_c && xfer_q.write && !xfer_q.err;
    assign bus_x_c  = decode(apb.PADDR, apb.PWRITE, apb.PWDATA, apb.PSTRB);
    assign resp_x_c = (phase_c == ST_SETUP) ? bus_x_c : xfer_q;

    // Read word with forwarding of a write committing on the same edge.
    always_comb begin
        rd_word_c = regs[resp_x_c.idx];
        if (commit_c && (xfer_q.idx == resp_x_c.idx)) begin
            rd_word_c = merge_bytes(rd_word_c, xfer_q.wdata, xfer_q.strb);
        end
`ifdef RO_ID_EN
        if (resp_x_c.idx == '0) begin
            rd_word_c = ID_VALUE;
        end
`endif
    end

    assign rdata_c = (resp_x_c.write || resp_x_c.err) ? 32'h0 : rd_word_c;

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        xfer_d    = xfer_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = 32'h0;
        case (phase_c)
            ST_SETUP: begin
                xfer_d  = bus_x_c;
                cnt_d   = WAIT_LOAD;
                state_d = ST_ACCESS;
                if (NO_WAIT) begin
                    pready_d  = 1'b1;
                    pslverr_d = bus_x_c.err;
                    prdata_d  = rdata_c;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else if (!(apb.PSEL && apb.PENABLE)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        pready_d  = 1'b1;
                        pslverr_d = xfer_q.err;
                        prdata_d  = rdata_c;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            xfer_q    <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= 32'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            xfer_q    <= xfer_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    // Register bank: byte-lane writes land on the edge closing the PREADY cycle.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int k = 0; k < int'(NUM_REGS); k++) begin
                regs[k] <= 32'h0;
            end
        end else if (commit_c) begin
            regs[xfer_q.idx] <= merge_bytes(regs[xfer_q.idx], xfer_q.wdata, xfer_q.strb);
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int k = 0; k < int'(NUM_REGS); k++) begin
            regs_flat[32*k +: 32] = regs[k];
        end
`ifdef RO_ID_EN
        regs_flat[31:0] = ID_VALUE;
`endif
    end

    assign apb.PREADY  = pready_q;
    assign apb.PSLVERR = pslverr_q;
    assign apb.PRDATA  = prdata_q;

endmodule
